cp0_except_unit: RTL and testbench
==================================

Name: cp0_except_unit

Overview:
- Coprocessor-0 register file plus precise-exception recognizer.
- Sits at the MEM/WB boundary and is the producer side of the pipeline controller's exception interface.
- Each cycle it inspects the MEM-stage instruction's exception flags and pending interrupts, then drives the 32-bit exception type code and the forwarded EPC.
- It commits EPC/Status/Cause updates at the clock edge; the pipeline controller turns those codes into flush and new PC.

Parameters:
- PRID, 32'h004c_0102, read-only value of register 15.
- CONFIG, 32'h0000_8000, read-only value of register 16.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_int  in  6  hardware interrupt lines, level-sensitive
- i_we  in  1  MTC0 write enable (WB stage)
- i_waddr  in  5  MTC0 register number
- i_wdata  in  32  MTC0 data
- i_raddr  in  5  MFC0 register number
- o_rdata  out  32  MFC0 data, combinational, no forwarding
- i_mem_valid  in  1  MEM stage holds a real instruction (not bubble or stalled)
- i_mem_pc  in  32  MEM-stage instruction address
- i_mem_in_dslot  in  1  MEM instruction is in a delay slot
- i_mem_exc  in  5  {eret, ov, trap, ri, syscall} flags
- o_except_type  out  32  to pipeline controller; 0 = none
- o_cp0_epc  out  32  forwarded EPC for ERET target
- o_timer_int  out  1  Count==Compare pending flag

Behaviour:
- Registers: Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15), Config(16). All other addresses read 0 and ignore writes.
- Reset values:
  - Count 0, Compare 0, Cause 0, EPC 0.
  - Status 32'h1000_0000.
  - o_timer_int 0.
  - o_except_type 0, because the reset Status has IE=0 and no flags are present.
- Count: increments by 1 every cycle with 32-bit wrap. An MTC0 to Count loads i_wdata, and that write wins over the increment.
- Timer:
  - Sets when Compare!=0 and Count==Compare.
  - Holds until any MTC0 to Compare, which clears it. A Compare write wins over a same-cycle match.
- Cause.IP[7:2]: registered every cycle from {i_int[5] | o_timer_int, i_int[4:0]}.
- Cause.IP[1:0]: software-writable via MTC0. Other Cause bits are not MTC0-writable.
- Status: fully MTC0-writable.
- EPC: MTC0-writable.
- Forwarding for exception decode: Status, Cause and EPC values used combinationally are the WB MTC0 value when i_we targets them this cycle. This forwarded EPC drives o_cp0_epc.
- o_except_type is combinational, zero unless i_mem_valid=1. Priority is highest first:
  - Interrupt, 32'h01: when (IP & IM)!=0, IE=1 and EXL=0.
  - syscall, 32'h08.
  - ri, 32'h0a.
  - trap, 32'h0d.
  - ov, 32'h0c.
  - eret, 32'h0e.
- Commit at the clock edge when o_except_type!=0:
  - Apply the MTC0 first, then the exception fields override it.
  - For non-ERET types with EXL=0:
    - EPC <= i_mem_in_dslot ? i_mem_pc-4 : i_mem_pc.
    - Cause.BD <= i_mem_in_dslot.
  - For non-ERET types with EXL=1: EPC and BD are unchanged.
  - For all non-ERET types:
    - EXL <= 1.
    - Cause.ExcCode[6:2] <= 0/8/10/13/12 respectively.
  - For ERET: EXL <= 0 only.
- Nested exceptions while EXL=1:
  - Interrupts are masked.
  - Synchronous exceptions are still signalled, without EPC update.
- Reset mid-operation: all state returns to reset values immediately; no pending exception survives.

Test Plan:
- Reset, then run 10 cycles with no writes -> Count reads 10 via i_raddr=9; o_except_type=0; Status reads 32'h1000_0000.
- MTC0 Compare=20, then Status=32'h1000_8001 (IM7, IE) -> at Count==20 o_timer_int=1. Next cycle Cause.IP7=1; with i_mem_valid=1, o_except_type=32'h01. After the edge, EXL=1, ExcCode=0, EPC=i_mem_pc. MTC0 Compare=0 -> o_timer_int=0.
- i_mem_exc=syscall|ov, pc=32'h100, in_dslot=1 -> o_except_type=32'h08; after the edge EPC=32'hFC, BD=1, ExcCode=8, EXL=1.
- EXL=1, raise syscall at pc=32'h200 -> o_except_type=32'h08; EPC unchanged at 32'hFC.
- Same cycle: MTC0 EPC=32'h400 and i_mem_exc=eret -> o_except_type=32'h0e, o_cp0_epc=32'h400; after the edge EXL=0.
- i_int[2]=1 with IM4 set, IE=1, but i_mem_valid=0 -> o_except_type=0. Raising i_mem_valid -> 32'h01.

Source files
------------

// File: rtl/cp0_except_unit.sv
// Coprocessor-0 register file and precise-exception recognizer at the MEM/WB boundary.
// Exception decode sees same-cycle MTC0 writes to Status/Cause/EPC via forwarding.
module cp0_except_unit #(
  parameter logic [31:0] PRID   = 32'h004c_0102,
  parameter logic [31:0] CONFIG = 32'h0000_8000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [5:0]  i_int,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr,
  output logic [31:0] o_rdata,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_pc,
  input  logic        i_mem_in_dslot,
  input  logic [4:0]  i_mem_exc,
  output logic [31:0] o_except_type,
  output logic [31:0] o_cp0_epc,
  output logic        o_timer_int
);
  localparam logic [4:0] A_COUNT = 5'd9, A_COMPARE = 5'd11, A_STATUS = 5'd12,
                         A_CAUSE = 5'd13, A_EPC = 5'd14, A_PRID = 5'd15, A_CONFIG = 5'd16;
  localparam logic [31:0] T_INT = 32'h01, T_SYS = 32'h08, T_RI = 32'h0a,
                          T_TRAP = 32'h0d, T_OV = 32'h0c, T_ERET = 32'h0e;
  localparam logic [31:0] STATUS_RST = 32'h1000_0000;

  logic [31:0] count, compare, status, cause, epc;
  logic [31:0] status_f, cause_f, epc_f;
  logic [31:0] count_nxt, status_nxt, cause_nxt, epc_nxt;
  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc, int_req;

  assign wr_count   = i_we && (i_waddr == A_COUNT);
  assign wr_compare = i_we && (i_waddr == A_COMPARE);
  assign wr_status  = i_we && (i_waddr == A_STATUS);
  assign wr_cause   = i_we && (i_waddr == A_CAUSE);
  assign wr_epc     = i_we && (i_waddr == A_EPC);

  // Only IP[1:0] of Cause is software-writable.
  assign status_f  = wr_status ? i_wdata : status;
  assign cause_f   = wr_cause ? {cause[31:10], i_wdata[9:8], cause[7:0]} : cause;
  assign epc_f     = wr_epc ? i_wdata : epc;
  assign o_cp0_epc = epc_f;
  assign count_nxt = wr_count ? i_wdata : count + 32'd1;

  assign int_req = (|(cause_f[15:8] & status_f[15:8])) && status_f[0] && !status_f[1];

  always_comb begin
    o_except_type = '0;
    if (i_mem_valid) begin
      if      (int_req)      o_except_type = T_INT;
      else if (i_mem_exc[0]) o_except_type = T_SYS;
      else if (i_mem_exc[1]) o_except_type = T_RI;
      else if (i_mem_exc[2]) o_except_type = T_TRAP;
      else if (i_mem_exc[3]) o_except_type = T_OV;
      else if (i_mem_exc[4]) o_except_type = T_ERET;
    end
  end

  // MTC0 effects first, then exception fields override them.
  always_comb begin
    status_nxt         = status_f;
    cause_nxt          = cause_f;
    epc_nxt            = epc_f;
    cause_nxt[15:10]   = {i_int[5] | o_timer_int, i_int[4:0]};
    if (o_except_type == T_ERET) begin
      status_nxt[1] = 1'b0;
    end else if (o_except_type != '0) begin
      if (!status_f[1]) begin
        epc_nxt       = i_mem_in_dslot ? i_mem_pc - 32'd4 : i_mem_pc;
        cause_nxt[31] = i_mem_in_dslot;
      end
      status_nxt[1]  = 1'b1;
      cause_nxt[6:2] = (o_except_type == T_INT) ? 5'd0 : o_except_type[4:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count       <= '0;
      compare     <= '0;
      status      <= STATUS_RST;
      cause       <= '0;
      epc         <= '0;
      o_timer_int <= 1'b0;
    end else begin
      count  <= count_nxt;
      status <= status_nxt;
      cause  <= cause_nxt;
      epc    <= epc_nxt;
      if (wr_compare) begin
        compare     <= i_wdata;
        o_timer_int <= 1'b0;
      end else if (compare != '0 && count_nxt == compare) begin
        // Match is judged on the value Count takes at this edge, so the flag
        // rises in the same cycle Count reads equal to Compare.
        o_timer_int <= 1'b1;
      end
    end
  end

  always_comb begin
    case (i_raddr)
      A_COUNT:   o_rdata = count;
      A_COMPARE: o_rdata = compare;
      A_STATUS:  o_rdata = status;
      A_CAUSE:   o_rdata = cause;
      A_EPC:     o_rdata = epc;
      A_PRID:    o_rdata = PRID;
      A_CONFIG:  o_rdata = CONFIG;
      default:   o_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_cp0_except_unit.sv
// Directed walk through the CP0 exception scenarios followed by random traffic,
// all checked against a behavioural model of the CP0 registers.
module tb_cp0_except_unit;
  logic        i_clk = 1'b0, i_rst_n = 1'b0;
  logic [5:0]  i_int = '0;
  logic        i_we = 1'b0;
  logic [4:0]  i_waddr = '0, i_raddr = '0;
  logic [31:0] i_wdata = '0, i_mem_pc = '0;
  logic        i_mem_valid = 1'b0, i_mem_in_dslot = 1'b0;
  logic [4:0]  i_mem_exc = '0;
  logic [31:0] o_rdata, o_except_type, o_cp0_epc;
  logic        o_timer_int;

  cp0_except_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_int(i_int), .i_we(i_we), .i_waddr(i_waddr),
    .i_wdata(i_wdata), .i_raddr(i_raddr), .o_rdata(o_rdata), .i_mem_valid(i_mem_valid),
    .i_mem_pc(i_mem_pc), .i_mem_in_dslot(i_mem_in_dslot), .i_mem_exc(i_mem_exc),
    .o_except_type(o_except_type), .o_cp0_epc(o_cp0_epc), .o_timer_int(o_timer_int)
  );

  always #5 i_clk = ~i_clk;

  int passed = 0, total = 0;
  // model state
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_timer;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_count = 0; m_compare = 0; m_status = 32'h1000_0000;
    m_cause = 0; m_epc = 0; m_timer = 0;
  endtask

  function automatic bit wr(input int a);
    return i_we && (int'(i_waddr) == a);
  endfunction

  function automatic logic [31:0] fwd_status();
    return wr(12) ? i_wdata : m_status;
  endfunction
  function automatic logic [31:0] fwd_cause();
    logic [31:0] c;
    c = m_cause;
    if (wr(13)) begin c[8] = i_wdata[8]; c[9] = i_wdata[9]; end
    return c;
  endfunction
  function automatic logic [31:0] fwd_epc();
    return wr(14) ? i_wdata : m_epc;
  endfunction

  function automatic logic [31:0] exp_type();
    logic [31:0] s, c;
    s = fwd_status(); c = fwd_cause();
    if (!i_mem_valid) return 0;
    if (((c >> 8) & (s >> 8) & 32'hff) != 0 && s[0] && !s[1]) return 32'h01;
    if (i_mem_exc[0]) return 32'h08;
    if (i_mem_exc[1]) return 32'h0a;
    if (i_mem_exc[2]) return 32'h0d;
    if (i_mem_exc[3]) return 32'h0c;
    if (i_mem_exc[4]) return 32'h0e;
    return 0;
  endfunction

  function automatic logic [31:0] exp_rdata();
    case (int'(i_raddr))
      9: return m_count;   11: return m_compare; 12: return m_status;
      13: return m_cause;  14: return m_epc;     15: return 32'h004c_0102;
      16: return 32'h0000_8000;
      default: return 0;
    endcase
  endfunction

  // Check all combinational outputs for the inputs currently driven.
  task automatic check_comb();
    #1;
    chk("except_type", o_except_type, exp_type());
    chk("cp0_epc", o_cp0_epc, fwd_epc());
    chk("timer_int", {31'd0, o_timer_int}, {31'd0, m_timer});
    chk("rdata", o_rdata, exp_rdata());
  endtask

  // Advance one clock, computing the model's next state from pre-edge inputs.
  task automatic tick();
    logic [31:0] t, s, c, e, cnt, cmp;
    logic tm;
    t = exp_type(); s = fwd_status(); c = fwd_cause(); e = fwd_epc();
    cnt = wr(9) ? i_wdata : m_count + 1;
    cmp = wr(11) ? i_wdata : m_compare;
    if (wr(11)) tm = 0;
    else tm = m_timer | (m_compare != 0 && cnt == m_compare);
    c = (c & ~32'h0000_fc00) | ({26'd0, i_int[5] | m_timer, i_int[4:0]} << 10);
    if (t == 32'h0e) s = s & ~32'h2;
    else if (t != 0) begin
      if (!s[1]) begin
        e = i_mem_in_dslot ? i_mem_pc - 4 : i_mem_pc;
        c = i_mem_in_dslot ? (c | 32'h8000_0000) : (c & 32'h7fff_ffff);
      end
      s = s | 32'h2;
      c = (c & ~32'h7c) | (((t == 32'h01) ? 32'd0 : t) << 2);
    end
    @(posedge i_clk);
    m_count = cnt; m_compare = cmp; m_status = s; m_cause = c; m_epc = e; m_timer = tm;
    @(negedge i_clk);
  endtask

  task automatic idle();
    i_we = 0; i_mem_valid = 0; i_mem_exc = 0; i_mem_in_dslot = 0;
  endtask

  task automatic mtc0(input int a, input logic [31:0] d);
    i_we = 1; i_waddr = a[4:0]; i_wdata = d;
    check_comb(); tick();
    i_we = 0;
  endtask

  task automatic rd(input string tag, input int a, input logic [31:0] exp);
    i_raddr = a[4:0];
    #1 chk(tag, o_rdata, exp);
  endtask

  initial begin
    int n;
    model_reset();
    @(negedge i_clk);
    // reset state
    check_comb();
    rd("rst_status", 12, 32'h1000_0000);
    chk("rst_type", o_except_type, 0);
    i_rst_n = 1;
    for (int i = 0; i < 10; i++) begin i_raddr = 5'd9; check_comb(); tick(); end
    rd("count10", 9, 32'd10);
    chk("idle_type", o_except_type, 0);
    rd("status_idle", 12, 32'h1000_0000);

    // timer interrupt
    mtc0(11, 32'd20);
    mtc0(12, 32'h1000_8001);
    n = 0;
    i_raddr = 5'd9;
    while (!o_timer_int && n < 50) begin check_comb(); tick(); n++; end
    chk("timer_seen", {31'd0, o_timer_int}, 32'd1);
    rd("count_at_match", 9, 32'd20);
    check_comb(); tick();
    rd("ip7", 13, m_cause & 32'h8000);
    chk("ip7_set", m_cause & 32'h8000, 32'h8000);
    i_mem_valid = 1; i_mem_pc = 32'h80;
    check_comb();
    chk("int_type", o_except_type, 32'h01);
    tick(); idle();
    rd("int_status", 12, 32'h1000_8003);
    rd("int_exccode", 13, m_cause);
    chk("int_exccode_v", o_rdata & 32'h7c, 0);
    rd("int_epc", 14, 32'h80);
    mtc0(11, 32'd0);
    chk("timer_clr", {31'd0, o_timer_int}, 0);

    // syscall|ov in delay slot with EXL cleared
    mtc0(12, 32'h1000_0000);
    i_mem_valid = 1; i_mem_exc = 5'b01001; i_mem_pc = 32'h100; i_mem_in_dslot = 1;
    check_comb();
    chk("sys_type", o_except_type, 32'h08);
    tick(); idle();
    rd("sys_epc", 14, 32'hfc);
    rd("sys_cause", 13, m_cause);
    chk("sys_bd_code", o_rdata & 32'h8000_007c, 32'h8000_0020);
    rd("sys_exl", 12, 32'h1000_0002);

    // nested syscall keeps EPC
    i_mem_valid = 1; i_mem_exc = 5'b00001; i_mem_pc = 32'h200;
    check_comb();
    chk("nest_type", o_except_type, 32'h08);
    tick(); idle();
    rd("nest_epc", 14, 32'hfc);

    // eret with same-cycle EPC write
    i_we = 1; i_waddr = 5'd14; i_wdata = 32'h400;
    i_mem_valid = 1; i_mem_exc = 5'b10000;
    check_comb();
    chk("eret_type", o_except_type, 32'h0e);
    chk("eret_epc", o_cp0_epc, 32'h400);
    tick(); idle();
    rd("eret_exl", 12, 32'h1000_0000);

    // interrupt gated by mem_valid
    mtc0(12, 32'h1000_1001);
    i_int = 6'b000100;
    check_comb(); tick();
    check_comb();
    chk("novalid_type", o_except_type, 0);
    i_mem_valid = 1;
    check_comb();
    chk("valid_int_type", o_except_type, 32'h01);
    tick(); idle(); i_int = 0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int pick;
      i_int = 6'($urandom_range(0, 63) & ($urandom_range(0, 1) ? 6'h3f : 6'h00));
      i_we = ($urandom_range(0, 3) == 0);
      pick = $urandom_range(0, 8);
      case (pick)
        0: i_waddr = 5'd9;  1: i_waddr = 5'd11; 2: i_waddr = 5'd12;
        3: i_waddr = 5'd13; 4: i_waddr = 5'd14; 5: i_waddr = 5'd15;
        6: i_waddr = 5'd16; 7: i_waddr = 5'd0;  default: i_waddr = 5'($urandom);
      endcase
      i_wdata = $urandom;
      if (i_waddr == 5'd11) i_wdata = m_count + $urandom_range(1, 6);
      if (i_waddr == 5'd12) i_wdata = i_wdata & 32'hffff_ff03;
      i_raddr = 5'($urandom_range(8, 17));
      i_mem_valid = $urandom_range(0, 1);
      i_mem_exc = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      i_mem_pc = $urandom & 32'hffff_fffc;
      i_mem_in_dslot = $urandom_range(0, 1);
      check_comb(); tick();
    end

    // asynchronous reset mid-operation
    idle(); i_int = 0;
    i_mem_valid = 1; i_mem_exc = 5'b00001;
    #2 i_rst_n = 0;
    model_reset();
    i_mem_exc = 0;
    rd("mid_rst_count", 9, 0);
    rd("mid_rst_status", 12, 32'h1000_0000);
    rd("mid_rst_epc", 14, 0);
    chk("mid_rst_timer", {31'd0, o_timer_int}, 0);
    chk("mid_rst_type", o_except_type, 0);
    @(posedge i_clk); @(negedge i_clk);
    i_rst_n = 1; idle();
    i_raddr = 5'd9;
    check_comb(); tick();
    rd("post_rst_count", 9, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
